// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion logic.
// Optional macro SAR_SETTLE_EN adds the SETTLE state.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_TRIAL,
`ifdef SAR_SETTLE_EN
    S_SETTLE,
`endif
    S_STROBE,
    S_WAIT,
    S_DONE
  } sar_state_e;

  localparam int unsigned WAIT_TIMEOUT = 16;
  localparam int unsigned TMO_W        = $clog2(WAIT_TIMEOUT);
  localparam int unsigned SETTLE_W     = 4;

endpackage

// File: rtl/sar_cnt.sv
// Loadable down-counter with a zero flag; stops at zero.
module sar_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sar_logic.sv
// SAR conversion sequencer: sample, per-bit trial/strobe/wait, result capture.
// Macro SAR_SETTLE_EN adds the settle_cycles port and SETTLE state.
module sar_logic
  import sar_pkg::*;
#(
  parameter int unsigned Ndac  = 16,
  parameter int unsigned Nsamp = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                comp_out,
  input  logic                comp_valid,
`ifdef SAR_SETTLE_EN
  input  logic [SETTLE_W-1:0] settle_cycles,
`endif
  output logic                sample,
  output logic [Ndac-1:0]     dac_state,
  output logic                comp_strobe,
  output logic                busy,
  output logic                done,
  output logic [Ndac-1:0]     dout,
  output logic                timeout
);

  localparam int unsigned BIT_W  = (Ndac > 1)  ? $clog2(Ndac)  : 1;
  localparam int unsigned SAMP_W = (Nsamp > 1) ? $clog2(Nsamp) : 1;

  sar_state_e        state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [Ndac-1:0]   dac_q, dac_d, dout_q, dout_d;
  logic              sample_q, sample_d, strobe_q, strobe_d;
  logic              busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic              samp_load, samp_dec, samp_zero;
  logic              tmo_load, tmo_dec, tmo_zero;

  sar_cnt #(.W(SAMP_W)) u_samp_cnt (
    .clk(clk), .rst(rst), .load(samp_load), .load_val(SAMP_W'(Nsamp - 1)),
    .dec(samp_dec), .zero(samp_zero)
  );

  sar_cnt #(.W(TMO_W)) u_tmo_cnt (
    .clk(clk), .rst(rst), .load(tmo_load), .load_val(TMO_W'(WAIT_TIMEOUT - 1)),
    .dec(tmo_dec), .zero(tmo_zero)
  );

`ifdef SAR_SETTLE_EN
  logic set_load, set_dec, set_zero;

  sar_cnt #(.W(SETTLE_W)) u_set_cnt (
    .clk(clk), .rst(rst), .load(set_load), .load_val(settle_cycles - SETTLE_W'(1)),
    .dec(set_dec), .zero(set_zero)
  );
`endif

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    dac_d     = dac_q;
    dout_d    = dout_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    samp_load = 1'b0;
    samp_dec  = 1'b0;
    tmo_load  = 1'b0;
    tmo_dec   = 1'b0;
`ifdef SAR_SETTLE_EN
    set_load  = 1'b0;
    set_dec   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SAMPLE;
          dac_d     = '0;
          bit_d     = BIT_W'(Ndac - 1);
          timeout_d = 1'b0;
          samp_load = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (samp_zero) state_d = S_TRIAL;
        else           samp_dec = 1'b1;
      end
      S_TRIAL: begin
        dac_d[bit_q] = 1'b1;
        state_d      = S_STROBE;
`ifdef SAR_SETTLE_EN
        if (settle_cycles != '0) begin
          state_d  = S_SETTLE;
          set_load = 1'b1;
        end
`endif
      end
`ifdef SAR_SETTLE_EN
      S_SETTLE: begin
        if (set_zero) state_d = S_STROBE;
        else          set_dec = 1'b1;
      end
`endif
      S_STROBE: begin
        state_d  = S_WAIT;
        tmo_load = 1'b1;
      end
      S_WAIT: begin
        // A real decision wins over a timeout expiring in the same cycle.
        if (comp_valid || tmo_zero) begin
          dac_d[bit_q] = comp_valid & comp_out;
          if (!comp_valid) timeout_d = 1'b1;
          if (bit_q == '0) begin
            state_d = S_DONE;
          end else begin
            bit_d   = bit_q - BIT_W'(1);
            state_d = S_TRIAL;
          end
        end else begin
          tmo_dec = 1'b1;
        end
      end
      S_DONE: begin
        dout_d  = dac_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they align with it.
    sample_d = (state_d == S_SAMPLE);
    strobe_d = (state_d == S_STROBE);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_q     <= '0;
      dac_q     <= '0;
      dout_q    <= '0;
      sample_q  <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      dac_q     <= dac_d;
      dout_q    <= dout_d;
      sample_q  <= sample_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign sample      = sample_q;
  assign dac_state   = dac_q;
  assign comp_strobe = strobe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dout        = dout_q;
  assign timeout     = timeout_q;

endmodule

// File: doc/sar_logic.md
SAR_LOGIC -- requirements
Module: sar_logic

Interface
REQ-001 Parameter Ndac, default 16: number of DAC bits; sets the width of dac_state and dout.
REQ-002 Parameter Nsamp, default 2, minimum 1: number of sampling-phase cycles.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  conversion request; honoured only in IDLE.
REQ-006 comp_out  input  1  comparator decision: 1 keeps the trial bit, 0 clears it.
REQ-007 comp_valid  input  1  comp_out qualifier; honoured only in WAIT.
REQ-008 sample  output  1  sampling switch enable for the capacitor array.
REQ-009 dac_state  output  Ndac  capacitor array control bus, MSB = bit Ndac-1.
REQ-010 comp_strobe  output  1  comparator clock pulse.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when dout is updated.
REQ-013 dout  output  Ndac  last conversion result.
REQ-014 timeout  output  1  sticky flag: a comparator decision timed out.
REQ-015 settle_cycles  input  4  settling cycles per bit; this port exists only when SAR_SETTLE_EN is defined.

Function
REQ-016 The state machine shall have the states IDLE, SAMPLE, TRIAL, SETTLE (only with SAR_SETTLE_EN), STROBE, WAIT and DONE; all outputs shall be registered.
REQ-017 IDLE: start=1 -> SAMPLE; in the same edge, dac_state <= 0, bit index <= Ndac-1, timeout <= 0.
REQ-018 SAMPLE: sample=1 for exactly Nsamp cycles, then -> TRIAL.
REQ-019 TRIAL (1 cycle): dac_state[bit] = 1, with already-resolved bits held; then -> STROBE, or -> SETTLE if SAR_SETTLE_EN is defined and settle_cycles != 0.
REQ-020 STROBE: comp_strobe=1 for exactly one cycle, then -> WAIT; comp_strobe is 0 in every other state.
REQ-021 WAIT: on comp_valid=1, dac_state[bit] <= comp_out; if bit==0 -> DONE, otherwise bit decrements and -> TRIAL.
REQ-022 WAIT timeout: if comp_valid has not arrived within 16 WAIT cycles, dac_state[bit] <= 0, timeout <= 1, and the FSM proceeds as in REQ-021.
REQ-023 DONE (1 cycle): dout <= dac_state, done=1, then -> IDLE; dac_state holds its value until the next start.
REQ-024 With comp_valid in the first WAIT cycle and no settling, done shall be high exactly Nsamp+3*Ndac+1 cycles after the edge that accepts start (51 cycles for the defaults).
REQ-025 start while busy=1 (including in DONE) shall be ignored; it shall not be queued.
REQ-026 comp_valid outside WAIT shall be ignored.
REQ-027 start and comp_valid arriving in the same cycle in IDLE: the start is accepted and comp_valid is ignored.

Reset
REQ-028 Asserting rst shall immediately force: state IDLE, sample=0, comp_strobe=0, busy=0, done=0, timeout=0, dac_state=0, dout=0, all counters 0.
REQ-029 Reset mid-conversion shall abort the conversion with no done pulse; after rst deasserts, a new start begins from REQ-017.

Configuration
REQ-030 Macro SAR_SETTLE_EN defined: settle_cycles is present; SETTLE lasts settle_cycles cycles (0 skips SETTLE); per-bit latency becomes 3+settle_cycles.
REQ-031 Macro SAR_SETTLE_EN undefined: no settle_cycles port, no SETTLE state; TRIAL goes directly to STROBE.

Structure
REQ-032 Package sar_pkg shall hold the state enum typedef, the WAIT timeout constant (16) and the settle counter width (4).
REQ-033 One sub-module, sar_cnt, shall be used: a loadable down-counter with a zero flag, instanced for sample, settle and timeout counting.

Verification
REQ-034 Defaults; start pulse; comp_valid one cycle after each strobe; comp_out pattern 0xA5C3 MSB first -> dout=0xA5C3, done at cycle 51, timeout=0.
REQ-035 comp_out always 1 -> dout=0xFFFF; comp_out always 0 -> dout=0x0000; dac_state shows exactly one new trial bit per TRIAL cycle.
REQ-036 comp_valid never asserted -> each bit times out after 16 WAIT cycles, dout=0x0000, timeout=1; next start clears timeout.
REQ-037 rst asserted during WAIT of bit 7 -> all outputs reach their reset values immediately, no done pulse; a following conversion completes correctly.
REQ-038 Extra start pulses during busy and during DONE -> ignored; exactly one done pulse per accepted start.
REQ-039 SAR_SETTLE_EN defined with settle_cycles=3 -> each bit takes 6 cycles, done at cycle 2+96+1=99; with settle_cycles=0 -> timing matches REQ-034.
